// File: rtl/multi_add_pipe_pkg.sv
// rtl/multi_add_pipe_pkg.sv - sizing helpers for the pipelined multi-operand adder tree
package multi_add_pipe_pkg;

  // Number of pairwise adder levels needed to reduce n operands to one sum
  function automatic int num_levels(input int n);
    return $clog2(n);
  endfunction

  // Element count after lvl levels of pairwise reduction (odd tail passes through)
  function automatic int level_elems(input int n, input int lvl);
    int c;
    c = n;
    for (int j = 0; j < lvl; j++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

  // Element offset of level lvl inside the flat bus holding levels 1..L
  function automatic int level_offset(input int n, input int lvl);
    int s;
    s = 0;
    for (int j = 1; j < lvl; j++) begin
      s += level_elems(n, j);
    end
    return s;
  endfunction

  // Smallest output width that cannot overflow for n operands of w bits
  function automatic int default_out_w(input int n, input int w);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/multi_add_pipe_add_tree_level.sv
// rtl/multi_add_pipe_add_tree_level.sv - one registered level of the pairwise adder tree
module multi_add_pipe_add_tree_level
  import multi_add_pipe_pkg::*;
#(
  parameter int N_EL  = 2,
  parameter int OUT_W = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic                                   in_valid,
  input  logic [N_EL*OUT_W-1:0]                  in_data,
  input  logic [OUT_W-1:0]                       bias,
  output logic                                   out_valid,
  output logic [level_elems(N_EL, 1)*OUT_W-1:0]  out_data,
  output logic [OUT_W-1:0]                       head_nxt
);
  localparam int N_OUT = level_elems(N_EL, 1);

  logic [N_OUT*OUT_W-1:0] pair_sum;
  logic [N_OUT*OUT_W-1:0] data_d, data_q;
  logic                   valid_d, valid_q;

  // Pairwise sums; a lone tail element passes through; bias only joins element 0
  for (genvar k = 0; k < N_OUT; k++) begin : g_pair
    if (2 * k + 1 < N_EL) begin : g_add
      assign pair_sum[k*OUT_W +: OUT_W] = in_data[2*k*OUT_W +: OUT_W]
                                        + in_data[(2*k+1)*OUT_W +: OUT_W]
                                        + ((k == 0) ? bias : {OUT_W{1'b0}});
    end else begin : g_pass
      assign pair_sum[k*OUT_W +: OUT_W] = in_data[2*k*OUT_W +: OUT_W]
                                        + ((k == 0) ? bias : {OUT_W{1'b0}});
    end
  end

  assign head_nxt = pair_sum[OUT_W-1:0];

  // Advance when enabled; data only loads for a real vector so bubbles leave it alone
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = pair_sum;
      end
    end
  end

  // Level register with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/multi_add_pipe.sv
// rtl/multi_add_pipe.sv - pipelined multi-operand adder; MULTI_ADD_PIPE_ACC_EN enables the accumulator
module multi_add_pipe
  import multi_add_pipe_pkg::*;
#(
  parameter int N_IN   = 9,
  parameter int W      = 1,
  parameter int SIGNED = 0,
  parameter int OUT_W  = default_out_w(N_IN, W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_IN*W-1:0]   in_data,
  input  logic                in_acc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_sum
);
  localparam int L          = num_levels(N_IN);
  localparam int TREE_ELEMS = level_offset(N_IN, L + 1);

  logic                     stall, en;
  logic                     stage0_valid_d, stage0_valid_q;
  logic [N_IN*OUT_W-1:0]    stage0_ext, stage0_data_d, stage0_data_q;
  logic [TREE_ELEMS*OUT_W-1:0] tree_bus;
  logic [L:0]               lvl_valid;
  logic [OUT_W-1:0]         bias_final, head_final;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  // Widen each operand to the output width before it enters the tree
  for (genvar k = 0; k < N_IN; k++) begin : g_ext
    if (SIGNED != 0) begin : g_sx
      assign stage0_ext[k*OUT_W +: OUT_W] = {{(OUT_W-W){in_data[k*W+W-1]}}, in_data[k*W +: W]};
    end else begin : g_zx
      assign stage0_ext[k*OUT_W +: OUT_W] = {{(OUT_W-W){1'b0}}, in_data[k*W +: W]};
    end
  end

  // Stage 0 captures the extended vector whenever the pipe is not stalled
  always_comb begin
    stage0_valid_d = stage0_valid_q;
    stage0_data_d  = stage0_data_q;
    if (en) begin
      stage0_valid_d = in_valid;
      if (in_valid) begin
        stage0_data_d = stage0_ext;
      end
    end
  end

  // Stage 0 register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage0_valid_q <= 1'b0;
      stage0_data_q  <= '0;
    end else begin
      stage0_valid_q <= stage0_valid_d;
      stage0_data_q  <= stage0_data_d;
    end
  end

  assign lvl_valid[0] = stage0_valid_q;

  for (genvar i = 1; i <= L; i++) begin : g_lvl
    localparam int N_EL  = level_elems(N_IN, i - 1);
    localparam int N_OUT = level_elems(N_IN, i);
    localparam int OFS   = level_offset(N_IN, i);

    logic [N_EL*OUT_W-1:0] lvl_in;
    logic [OUT_W-1:0]      lvl_bias, head_nxt;
    logic                  unused_head;

    if (i == 1) begin : g_first
      assign lvl_in = stage0_data_q;
    end else begin : g_inner
      assign lvl_in = tree_bus[level_offset(N_IN, i - 1)*OUT_W +: N_EL*OUT_W];
    end

    if (i == L) begin : g_last
      assign lvl_bias   = bias_final;
      assign head_final = head_nxt;
    end else begin : g_mid
      assign lvl_bias = '0;
    end

    assign unused_head = ^head_nxt;

    multi_add_pipe_add_tree_level #(
      .N_EL  (N_EL),
      .OUT_W (OUT_W)
    ) u_lvl (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (lvl_valid[i-1]),
      .in_data   (lvl_in),
      .bias      (lvl_bias),
      .out_valid (lvl_valid[i]),
      .out_data  (tree_bus[OFS*OUT_W +: N_OUT*OUT_W]),
      .head_nxt  (head_nxt)
    );
  end

  assign out_valid = lvl_valid[L];
  assign out_sum   = tree_bus[level_offset(N_IN, L)*OUT_W +: OUT_W];

`ifdef MULTI_ADD_PIPE_ACC_EN
  logic [L-1:0]     acc_pipe_d, acc_pipe_q;
  logic [OUT_W-1:0] acc_d, acc_q;

  // Carry the in_acc sideband alongside its vector, frozen on stall
  always_comb begin
    acc_pipe_d = acc_pipe_q;
    if (en) begin
      acc_pipe_d[0] = in_acc;
      for (int i = 1; i < L; i++) begin
        acc_pipe_d[i] = acc_pipe_q[i-1];
      end
    end
  end

  // Accumulator tracks whatever the final stage loads into out_sum
  always_comb begin
    acc_d = acc_q;
    if (en && lvl_valid[L-1]) begin
      acc_d = head_final;
    end
  end

  // Sideband and accumulator registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_pipe_q <= '0;
      acc_q      <= '0;
    end else begin
      acc_pipe_q <= acc_pipe_d;
      acc_q      <= acc_d;
    end
  end

  assign bias_final = acc_pipe_q[L-1] ? acc_q : '0;
`else
  logic unused_acc;

  assign bias_final = '0;
  assign unused_acc = in_acc ^ (^head_final);
`endif

endmodule

// File: tb/tb_multi_add_pipe.sv
// tb/tb_multi_add_pipe.sv - scoreboard bench for multi_add_pipe
module tb_multi_add_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance: N_IN=9, W=1
  logic        in_valid_m, in_ready_m, in_acc_m, out_valid_m, out_ready_m;
  logic [8:0]  in_data_m;
  logic [4:0]  out_sum_m;
  // signed instance: N_IN=5, W=8, SIGNED=1
  logic        in_valid_s, in_ready_s, in_acc_s, out_valid_s, out_ready_s;
  logic [39:0] in_data_s;
  logic [10:0] out_sum_s;
  // accumulate instance: N_IN=4, W=8, OUT_W=10
  logic        in_valid_a, in_ready_a, in_acc_a, out_valid_a, out_ready_a;
  logic [31:0] in_data_a;
  logic [9:0]  out_sum_a;

  multi_add_pipe #(.N_IN(9), .W(1), .SIGNED(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .in_data(in_data_m), .in_acc(in_acc_m), .out_valid(out_valid_m),
    .out_ready(out_ready_m), .out_sum(out_sum_m));

  multi_add_pipe #(.N_IN(5), .W(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_data(in_data_s), .in_acc(in_acc_s), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .out_sum(out_sum_s));

  multi_add_pipe #(.N_IN(4), .W(8), .SIGNED(0), .OUT_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_acc(in_acc_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_sum(out_sum_a));

  logic [31:0] exp_m[$], exp_s[$], exp_a[$];
  int          outc_m[$], outc_s[$];
  int          cnt_a = 0;
  int          stall_seen = 0;
  int          acc_m = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int qsize(input int which);
    if (which == 0) return exp_m.size();
    if (which == 1) return exp_s.size();
    return exp_a.size();
  endfunction

  function automatic logic [31:0] model_s(input logic [39:0] d);
    int s;
    logic [7:0] b;
    s = 0;
    for (int k = 0; k < 5; k++) begin
      b = d[k*8 +: 8];
      s += int'($signed(b));
    end
    return 32'(s) & 32'h7FF;
  endfunction

  function automatic logic [31:0] model_a(input logic [31:0] d, input logic acc);
    int t;
    t = int'(d[7:0]) + int'(d[15:8]) + int'(d[23:16]) + int'(d[31:24]);
`ifdef MULTI_ADD_PIPE_ACC_EN
    if (acc) t = acc_m + t;
`else
    if (acc) t = t + 0;
`endif
    t = t % 1024;
    acc_m = t;
    return 32'(t);
  endfunction

  // output monitors: pop the scoreboard on every output transfer
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && out_valid_m && out_ready_m) begin
      e = (exp_m.size() > 0) ? exp_m.pop_front() : 32'hDEAD_BEEF;
      check_eq("sum_m", 32'(out_sum_m), e);
      outc_m.push_back(cyc);
    end
    if (rst_n && out_valid_m && !out_ready_m) begin
      stall_seen++;
      check_eq("stall_in_ready", 32'(in_ready_m), 32'd0);
    end
    if (rst_n && out_valid_s && out_ready_s) begin
      e = (exp_s.size() > 0) ? exp_s.pop_front() : 32'hDEAD_BEEF;
      check_eq("sum_s", 32'(out_sum_s), e);
      outc_s.push_back(cyc);
    end
    if (rst_n && out_valid_a && out_ready_a) begin
      e = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hDEAD_BEEF;
      check_eq("sum_a", 32'(out_sum_a), e);
      cnt_a++;
    end
  end

  task automatic send_m(input logic [8:0] d, output int ac);
    bit done;
    int n;
    done = 0; n = 0; ac = -1;
    in_valid_m = 1'b1; in_data_m = d;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready_m) begin
        exp_m.push_back(32'($countones(d)));
        ac = cyc; done = 1;
      end
      @(posedge clk); #1; n++;
    end
    in_valid_m = 1'b0;
    if (!done) check_eq("send_m_timeout", 32'(in_ready_m), 32'd1);
  endtask

  task automatic send_s(input logic [39:0] d, output int ac);
    bit done;
    int n;
    done = 0; n = 0; ac = -1;
    in_valid_s = 1'b1; in_data_s = d;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready_s) begin
        exp_s.push_back(model_s(d));
        ac = cyc; done = 1;
      end
      @(posedge clk); #1; n++;
    end
    in_valid_s = 1'b0;
    if (!done) check_eq("send_s_timeout", 32'(in_ready_s), 32'd1);
  endtask

  task automatic send_a(input logic [31:0] d, input logic acc);
    bit done;
    int n;
    done = 0; n = 0;
    in_valid_a = 1'b1; in_data_a = d; in_acc_a = acc;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready_a) begin
        exp_a.push_back(model_a(d, acc));
        done = 1;
      end
      @(posedge clk); #1; n++;
    end
    in_valid_a = 1'b0; in_acc_a = 1'b0;
    if (!done) check_eq("send_a_timeout", 32'(in_ready_a), 32'd1);
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    check_eq($sformatf("drain%0d", which), 32'(qsize(which)), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a, snap;
    logic [8:0] m;
    rst_n = 1'b0;
    in_valid_m = 0; in_data_m = '0; in_acc_m = 0; out_ready_m = 1;
    in_valid_s = 0; in_data_s = '0; in_acc_s = 0; out_ready_s = 1;
    in_valid_a = 0; in_data_a = '0; in_acc_a = 0; out_ready_a = 1;

    // reset state
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check_eq("rst_out_valid", 32'(out_valid_m), 32'd0);
      check_eq("rst_out_sum", 32'(out_sum_m), 32'd0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(in_ready_m), 32'd1);
    @(posedge clk); #1;

    // basic latency: all ones
    outc_m.delete();
    send_m(9'h1FF, a0);
    drain(0);
    check_eq("latency_m", 32'((outc_m.size() > 0) ? outc_m[0] - a0 : -1), 32'd5);

    // streaming 0..9 bits set, back to back
    outc_m.delete();
    for (int i = 0; i <= 9; i++) begin
      m = 9'((1 << i) - 1);
      send_m(m, a);
      if (i == 0) a0 = a;
    end
    drain(0);
    check_eq("stream_count", 32'(outc_m.size()), 32'd10);
    check_eq("stream_first", 32'((outc_m.size() > 0) ? outc_m[0] - a0 : -1), 32'd5);
    for (int i = 0; i + 1 < outc_m.size(); i++)
      check_eq($sformatf("stream_gap%0d", i), 32'(outc_m[i+1] - outc_m[i]), 32'd1);

    // backpressure while streaming
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          m = 9'((2 << i) - 1);
          send_m(m, a);
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready_m = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready_m = 1'b1;
      end
    join
    drain(0);
    check_eq("stall_cycles", 32'(stall_seen), 32'd4);

    // signed, odd operand count
    outc_s.delete();
    send_s({8'h80, 8'h04, 8'h03, 8'hFE, 8'hFF}, a0);
    drain(1);
    check_eq("latency_s", 32'((outc_s.size() > 0) ? outc_s[0] - a0 : -1), 32'd4);
    send_s({5{8'h80}}, a);
    send_s({5{8'h7F}}, a);
    send_s({8'h01, 8'hFF, 8'h00, 8'h10, 8'hF0}, a);
    drain(1);

    // wrap and accumulate
    send_a({4{8'hFF}}, 1'b0);
    send_a({4{8'h01}}, 1'b1);
    send_a({4{8'h01}}, 1'b0);
    drain(2);

    // reset with three vectors in flight
    send_a({4{8'h03}}, 1'b0);
    send_a({4{8'h05}}, 1'b1);
    send_a({4{8'h07}}, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_a.delete();
    acc_m = 0;
    snap = cnt_a;
    repeat (10) @(posedge clk);
    #1;
    check_eq("flush_a", 32'(cnt_a - snap), 32'd0);
    send_a({4{8'h02}}, 1'b1);
    drain(2);
    check_eq("acc_after_rst_count", 32'(cnt_a - snap), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_add_pipe.md
Name: multi_add_pipe

Overview:
- Parametrised, pipelined multi-operand adder. Sums N_IN operands of W bits each through a registered input stage and a registered binary adder tree.
- Valid/ready handshake on both sides; the whole pipeline stalls under output backpressure.
- Used wherever the datapath needs a wide registered sum of many narrow inputs, e.g. popcount or small reduction sums.

Parameters:
- N_IN, 9, number of operands; must be ≥2.
- W, 1, width of each operand in bits.
- SIGNED, 0, 1 = operands are two's complement and are sign-extended; 0 = zero-extended.
- OUT_W, W+$clog2(N_IN), output width. Must be ≥ the default; wider values extend operands further.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block accepts the vector this cycle.
- in_data  in  N_IN*W  operands packed; operand k at bits [k*W +: W].
- in_acc  in  1  accumulate request, carried with the vector as sideband.
- out_valid  out  1  out_sum valid.
- out_ready  in  1  downstream accepts out_sum.
- out_sum  out  OUT_W  registered sum.

Behaviour:
- Clock/reset (decided): one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset: on any edge with rst_n=0, all stage valids and out_valid go to 0, out_sum goes to 0, and the accumulator goes to 0. Data registers other than out_sum may keep their contents.
- Reset mid-operation discards all in-flight vectors. in_ready is 1 in the first cycle after reset.
- Pipeline structure: L = $clog2(N_IN) tree levels. Stage 0 registers the operands, extended to OUT_W. Level i registers the pairwise sums of level i-1. Level L is out_sum.
- Odd element count at a level: the last element passes through registered, unchanged.
- Latency: exactly L+1 cycles from an accepted input to out_valid with no stall. Example: N_IN=9 gives latency 5.
- Throughput: one vector per cycle.
- Stall rule: stall = out_valid & ~out_ready; in_ready = ~stall.
- When stall=1, every stage register holds, including valids and the in_acc sideband.
- When stall=0, every stage advances and the stage-0 valid loads in_valid.
- Bubbles are not collapsed.
- Transfer rules: input transfers when in_valid & in_ready. Output transfers when out_valid & out_ready. Simultaneous input and output transfer in one cycle is legal.
- Arithmetic: modulo 2^OUT_W, no saturation. With SIGNED=1, the result is a two's-complement OUT_W-bit value.
- in_data may change freely while in_valid=0.

Optional Feature:
- Macro: MULTI_ADD_PIPE_ACC_EN.
- Defined:
  - An OUT_W accumulator register holds the value of the last out_sum loaded.
  - At the final stage, if the vector's in_acc sideband is 1: out_sum <= acc + tree_sum and acc <= the same value.
  - Otherwise: out_sum <= tree_sum and acc <= tree_sum.
  - The accumulator updates only when the final stage loads a valid vector (stall=0 and level L-1 valid). It wraps modulo 2^OUT_W.
- Undefined: the in_acc port is still present but ignored; no accumulator register; out_sum = tree_sum.

Decomposition:
- Package multi_add_pipe_pkg:
  - function for level count.
  - function for element count at level i: ceil(prev/2).
  - function for default OUT_W.
- One sub-module is natural: add_tree_level.
  - Parameters: element count in, OUT_W.
  - Contents: registered pairwise adder with odd pass-through, valid bit, and enable (= ~stall).
  - multi_add_pipe instantiates L of them in a generate loop.

Test Plan:
- Reset and basic latency: N_IN=9, W=1; rst_n=0 for 2 cycles, then one vector of all ones → out_valid rises exactly 5 cycles after acceptance with out_sum=9. out_sum=0 and out_valid=0 during reset.
- Streaming: N_IN=9, W=1, out_ready=1; back-to-back vectors with 0,1,…,9 bits set → out_sum=0,1,…,9 on consecutive cycles, no bubbles.
- Backpressure: hold out_ready=0 for 4 cycles while streaming → in_ready=0 while out_valid=1; no vector lost or duplicated; order preserved after release.
- Signed and odd count: N_IN=5, W=8, SIGNED=1, inputs -1,-2,3,4,-128 → out_sum=-124 (OUT_W=11, 0x784); latency 4.
- Wrap and accumulate: with MULTI_ADD_PIPE_ACC_EN, N_IN=4, W=8, OUT_W=10.
  - Vector A = 4×255, in_acc=0 → out_sum=1020.
  - Vector B = 4×1, in_acc=1 → out_sum=0 (1024 mod 1024).
  - Vector C = 4×1, in_acc=0 → out_sum=4.
- Reset mid-flight: assert rst_n=0 for one cycle with 3 vectors in flight → none emerge afterwards; the accumulator reads 0 on the next in_acc=1 vector.
